// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the counter/scanner slice.
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  // Any code 10-15 blanks the downstream 7-segment decoder.
  localparam bcd_t BCD_BLANK = 4'hF;

  function automatic bcd_t bcd_sat(input bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD decade: steps up or down when step=1, flags carry/borrow out on wrap.
module bcd_digit_cell (
  input  logic       step,
  input  logic       up,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       co
);

  always_comb begin
    q  = d;
    co = 1'b0;
    if (step) begin
      if (up) begin
        if (d == 4'd9) begin
          q  = 4'd0;
          co = 1'b1;
        end else begin
          q = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          q  = 4'd9;
          co = 1'b1;
        end else begin
          q = d - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_count_scan.sv
// Multi-decade BCD up/down counter with a registered, time-multiplexed digit scanner
// driving an active-low anode vector and a BCD code for a 7-segment decoder.
module bcd_count_scan
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic [3:0]            DCBA,
  output logic [DIGITS-1:0]     an
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [TW-1:0]       r_tick_cnt;
  logic [SW-1:0]       r_scan_cnt;
  logic [IW-1:0]       r_scan_idx;
  logic [4*DIGITS-1:0] r_count;
  logic                r_carry;
  logic [3:0]          r_dcba;
  logic [DIGITS-1:0]   r_an;

  logic                w_tick;
  logic                w_scan_wrap;
  logic [DIGITS:0]     w_step;
  logic [4*DIGITS-1:0] w_next;
  logic [4*DIGITS-1:0] w_load_sat;
  logic [DIGITS-1:0]   w_lz;
  bcd_t                w_digit;
  logic                w_blank;

  assign w_tick      = en && (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_scan_wrap = (r_scan_cnt == SW'(SCAN_DIV - 1));
  assign w_step[0]   = w_tick;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .step (w_step[g]),
      .up   (up),
      .d    (r_count[4*g +: 4]),
      .q    (w_next[4*g +: 4]),
      .co   (w_step[g+1])
    );
    assign w_load_sat[4*g +: 4] = bcd_sat(load_val[4*g +: 4]);
  end

  // w_lz[i] marks digit i as a leading zero; digit 0 is never one.
  always_comb begin
    logic v_zero_above;
    v_zero_above = 1'b1;
    w_lz         = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      v_zero_above = v_zero_above && (r_count[4*i +: 4] == 4'd0);
      w_lz[i]      = v_zero_above;
    end
  end

  assign w_digit = r_count[4*r_scan_idx +: 4];
  assign w_blank = blank_lz && w_lz[r_scan_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
      r_count    <= '0;
      r_carry    <= 1'b0;
      r_an       <= '1;
      r_dcba     <= BCD_BLANK;
    end else begin
      if (clr) begin
        r_count    <= '0;
        r_tick_cnt <= '0;
        r_carry    <= 1'b0;
      end else begin
        if (en) r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
        if (load) begin
          r_count <= w_load_sat;
          r_carry <= 1'b0;
        end else if (w_tick) begin
          r_count <= w_next;
          r_carry <= w_step[DIGITS];
        end else begin
          r_carry <= 1'b0;
        end
      end

      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SW'(1);
      if (w_scan_wrap) begin
        r_scan_idx <= (r_scan_idx == IW'(DIGITS - 1)) ? '0 : r_scan_idx + IW'(1);
      end

      r_an   <= ~(DIGITS'(1) << r_scan_idx);
      r_dcba <= w_blank ? BCD_BLANK : w_digit;
    end
  end

  assign count = r_count;
  assign carry = r_carry;
  assign DCBA  = r_dcba;
  assign an    = r_an;

endmodule

// File: doc/bcd_count_scan.md
# bcd_count_scan

Multi-digit BCD up/down counter with a time-multiplexed digit scanner, sitting directly upstream of the single-digit BCD-to-7-segment decoder. Each cycle it drives one 4-bit BCD digit onto `DCBA` for the decoder and selects the matching display position with an active-low anode vector. Codes 10–15 blank the downstream decoder, so code 4'hF serves as the blank digit.

## Interface
- `DIGITS`, 4: number of decades and display positions (1–8).
- `TICK_DIV`, 50_000_000: clock cycles per count step.
- `SCAN_DIV`, 50_000: clock cycles per display position.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `en`  in  1: count enable; low freezes the tick prescaler and the count.
- `up`  in  1: 1 = count up, 0 = count down.
- `clr`  in  1: synchronous clear of the count.
- `load`  in  1: synchronous load of `load_val`.
- `load_val`  in  4*DIGITS: BCD value, digit 0 in bits [3:0].
- `blank_lz`  in  1: blank leading zeros.
- `count`  out  4*DIGITS: current BCD count.
- `carry`  out  1: one-cycle pulse on wrap, in either direction.
- `DCBA`  out  4: BCD code for the decoder.
- `an`  out  DIGITS: active-low position select, one-hot-low.

## Operation
- Tick prescaler:
  - Counts 0..TICK_DIV-1 while `en`=1.
  - `tick` fires on the cycle it equals TICK_DIV-1, then the prescaler wraps to 0.
  - Holds its value while `en`=0.
- Count priority: `clr` > `load` > `tick`.
  - `clr` zeroes the count and the tick prescaler.
  - `load` copies `load_val`; any digit >9 loads as 9.
  - `tick` steps the count by one.
- Up-count: ripple BCD increment. Digit 9 goes to 0 with carry to the next digit. All-9s wraps to all-0s and pulses `carry`.
- Down-count: digit 0 goes to 9 with borrow. All-0s wraps to all-9s and pulses `carry`.
- `clr` and `load` never pulse `carry`.
- Scan:
  - The scan prescaler counts 0..SCAN_DIV-1, free-running and independent of `en`.
  - At wrap, the scan index advances by one, going DIGITS-1 → 0.
  - For index i: `an[i]`=0, all other bits 1, `DCBA`=digit i.
- Leading-zero blanking (`blank_lz`=1):
  - Any digit above the most significant non-zero digit outputs 4'hF.
  - Digit 0 is never blanked, so a count of zero shows a single "0".

## Timing
- Reset values:
  - `count`=0, `carry`=0.
  - Both prescalers = 0, scan index = 0.
  - `an`=all ones (all positions off), `DCBA`=4'hF.
- `count` updates on the edge where tick/clr/load is sampled.
- `carry` is registered. It is high for exactly the one cycle in which `count` first shows the wrapped value.
- `DCBA` and `an` are registered. They reflect the scan index and count with one cycle of latency. The first valid digit appears on the cycle after reset deasserts.
- `an` and `DCBA` always change on the same edge. `an` never has two bits low at once.
- `clr` or `load` on the same cycle as `tick`: `clr`/`load` wins and the tick is discarded.
- Toggling `up` takes effect on the next tick. No count step is lost or doubled.
- Reset asserted mid-count or mid-scan: on the next edge, all state returns to reset values regardless of any other input.

## Structure
- Package `bcd_pkg`:
  - Constant `BCD_BLANK` = 4'hF.
  - Type `bcd_t` = logic [3:0].
  - Function `bcd_sat` clamps a digit >9 to 9.
- Sub-module `bcd_digit_cell`: one decade with inputs `step`, `up`, `d` and outputs `q`, `co`. Instantiate it DIGITS times in a ripple chain.
- Top level holds the two prescalers, the scan index, the leading-zero mask and the output registers.

## Test plan
Run with `DIGITS`=4, `TICK_DIV`=2, `SCAN_DIV`=3.
- Reset, `en`=1, `up`=1, 20 ticks → `count`=0x0020. `carry` never asserted. `an` cycles 1110→1101→1011→0111 every 3 cycles.
- `load` 0x9998, `up`=1, 2 ticks → 0x9999 then 0x0000. `carry` is high one cycle, coincident with 0x0000.
- `load` 0x0001, `up`=0, 2 ticks → 0x0000 then 0x9999, `carry` pulses once. `load` 0x00FA → `count`=0x0099.
- `blank_lz`=1, `count`=0x0042 → positions 3 and 2 show `DCBA`=F, positions 1 and 0 show 4 and 2. With `count`=0 → only position 0 shows 0.
- `clr`, `load` (0x1234) and tick in the same cycle → `count`=0x0000, no `carry`. `load`+tick in the same cycle → `count`=0x1234.
- Assert `rst_n`=0 mid-scan at `count`=0x0567 → next edge: `count`=0, `an`=1111, `DCBA`=F, `carry`=0.
